// File: rtl/epp_port_bridge.sv
// Bridges the CPU port bus and the Digilent EPP host interface. CPU words go to a TX FIFO
// that the host drains one byte at a time. Host byte pairs are packed into an RX FIFO that the CPU pops.
module epp_port_bridge #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned PORT_DATA   = 2,
    parameter int unsigned PORT_STATUS = 3
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    input  logic                 usb_write,
    input  logic                 usb_astb,
    input  logic                 usb_dstb,
    input  logic [7:0]           usb_db_in,
    output logic [7:0]           usb_db_out,
    output logic                 usb_db_oe,
    output logic                 usb_wait
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [WORD_SIZE-1:0] P_DATA   = PORT_DATA[WORD_SIZE-1:0];
    localparam logic [WORD_SIZE-1:0] P_STATUS = PORT_STATUS[WORD_SIZE-1:0];
    localparam logic [CW-1:0]        C_FULL   = DEPTH[CW-1:0];

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACT  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]            r_astb_sync, r_dstb_sync, r_write_sync;
    logic                  w_astb, w_dstb, w_write;

    logic [1:0]            r_state;
    logic                  r_is_addr;
    logic [7:0]            r_ep_addr;
    logic [7:0]            r_db_out;
    logic [WORD_SIZE-1:0]  r_portout;
    logic                  r_tx_toggle, r_rx_toggle;
    logic [7:0]            r_rx_low;
    logic                  r_tx_ovf, r_rx_ovf;

    logic [WORD_SIZE-1:0]  r_tx_mem [DEPTH];
    logic [WORD_SIZE-1:0]  r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [CW-1:0]         r_tx_count, r_rx_count;

    logic                  w_tx_full, w_tx_nonempty, w_rx_full, w_rx_nonempty;
    logic [WORD_SIZE-1:0]  w_tx_head, w_rx_head;
    logic                  w_act, w_data_rd, w_data_wr;
    logic                  w_tx_push_req, w_tx_push, w_tx_pop;
    logic                  w_rx_push_req, w_rx_push, w_rx_pop;
    logic                  w_status_clr;
    logic [7:0]            w_rd_byte;
    logic [3:0]            w_tx_cnt4, w_rx_cnt4;

    // Strobes idle high, so their synchronisers reset to 1 to avoid a spurious cycle.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_astb_sync  <= 2'b11;
            r_dstb_sync  <= 2'b11;
            r_write_sync <= 2'b00;
        end else begin
            r_astb_sync  <= {r_astb_sync[0], usb_astb};
            r_dstb_sync  <= {r_dstb_sync[0], usb_dstb};
            r_write_sync <= {r_write_sync[0], usb_write};
        end
    end

    assign w_astb  = r_astb_sync[1];
    assign w_dstb  = r_dstb_sync[1];
    assign w_write = r_write_sync[1];

    assign w_tx_full     = (r_tx_count == C_FULL);
    assign w_tx_nonempty = (r_tx_count != '0);
    assign w_rx_full     = (r_rx_count == C_FULL);
    assign w_rx_nonempty = (r_rx_count != '0);
    assign w_tx_head     = r_tx_mem[r_tx_rptr];
    assign w_rx_head     = r_rx_mem[r_rx_rptr];
    assign w_tx_cnt4     = 4'(r_tx_count);
    assign w_rx_cnt4     = 4'(r_rx_count);

    assign w_act     = (r_state == ST_ACT);
    assign w_data_rd = w_act && !r_is_addr && w_write;
    assign w_data_wr = w_act && !r_is_addr && !w_write;

    assign w_tx_push_req = portset && (portaddr == P_DATA);
    assign w_tx_pop      = w_data_rd && (r_ep_addr == 8'd0) && w_tx_nonempty && r_tx_toggle;
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);

    assign w_rx_pop      = portget && (portaddr == P_DATA) && w_rx_nonempty;
    assign w_rx_push_req = w_data_wr && (r_ep_addr == 8'd1) && r_rx_toggle;
    assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);

    assign w_status_clr  = portset && (portaddr == P_STATUS);

    always_comb begin
        w_rd_byte = '0;
        if (r_is_addr) begin
            w_rd_byte = r_ep_addr;
        end else begin
            case (r_ep_addr)
                8'd0: if (w_tx_nonempty) w_rd_byte = r_tx_toggle ? w_tx_head[15:8] : w_tx_head[7:0];
                8'd2: w_rd_byte = {4'b0, r_rx_ovf, r_tx_ovf, w_rx_full, w_tx_nonempty};
                default: w_rd_byte = '0;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= portval;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= {usb_db_in, r_rx_low};
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 1'b1;

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_is_addr   <= 1'b0;
            r_ep_addr   <= '0;
            r_db_out    <= '0;
            r_tx_toggle <= 1'b0;
            r_rx_toggle <= 1'b0;
            r_rx_low    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_astb || !w_dstb) begin
                        r_state   <= ST_ACT;
                        r_is_addr <= !w_astb;
                    end
                end
                ST_ACT: begin
                    r_state <= ST_HOLD;
                    if (w_write) r_db_out <= w_rd_byte;
                    else if (r_is_addr) r_ep_addr <= usb_db_in;
                    if (w_data_rd && (r_ep_addr == 8'd0) && w_tx_nonempty)
                        r_tx_toggle <= !r_tx_toggle;
                    if (w_data_wr && (r_ep_addr == 8'd1)) begin
                        r_rx_toggle <= !r_rx_toggle;
                        if (!r_rx_toggle) r_rx_low <= usb_db_in;
                    end
                end
                ST_HOLD: begin
                    if (w_astb && w_dstb) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A same-cycle overflow event takes precedence over the CPU clear.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_status_clr) begin
                r_tx_ovf <= 1'b0;
                r_rx_ovf <= 1'b0;
            end
            if (w_tx_push_req && !w_tx_push) r_tx_ovf <= 1'b1;
            if (w_rx_push_req && !w_rx_push) r_rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_portout <= '0;
        end else if (portget) begin
            if (portaddr == P_DATA)
                r_portout <= w_rx_nonempty ? w_rx_head : '0;
            else if (portaddr == P_STATUS)
                r_portout <= {w_rx_cnt4, w_tx_cnt4, 4'b0, r_rx_ovf, r_tx_ovf, w_rx_nonempty, w_tx_full};
        end
    end

    assign portout    = r_portout;
    assign usb_db_out = r_db_out;
    assign usb_wait   = (r_state != ST_IDLE);
    assign usb_db_oe  = (r_state == ST_HOLD) && w_write;

endmodule

// File: tb/tb_epp_port_bridge.sv
// Self-checking bench for epp_port_bridge: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_epp_port_bridge;
    logic        mclk = 1'b0;
    logic        rst_n;
    logic [15:0] portaddr, portval, portout;
    logic        portget, portset;
    logic        usb_write, usb_astb, usb_dstb, usb_db_oe, usb_wait;
    logic [7:0]  usb_db_in, usb_db_out;

    epp_port_bridge #(.WORD_SIZE(16), .DEPTH_LOG2(3), .PORT_DATA(2), .PORT_STATUS(3)) dut (
        .mclk(mclk), .rst_n(rst_n), .portaddr(portaddr), .portval(portval),
        .portget(portget), .portset(portset), .portout(portout),
        .usb_write(usb_write), .usb_astb(usb_astb), .usb_dstb(usb_dstb),
        .usb_db_in(usb_db_in), .usb_db_out(usb_db_out), .usb_db_oe(usb_db_oe),
        .usb_wait(usb_wait)
    );

    always #5 mclk = ~mclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view with queues
    logic [15:0] m_tx[$];
    logic [15:0] m_rx[$];
    bit          m_tx_tog, m_rx_tog, m_tx_ovf, m_rx_ovf;
    logic [7:0]  m_rx_low, m_addr;
    logic [15:0] m_portout;

    function automatic void m_reset();
        m_tx.delete(); m_rx.delete();
        m_tx_tog = 0; m_rx_tog = 0; m_tx_ovf = 0; m_rx_ovf = 0;
        m_rx_low = 0; m_addr = 0; m_portout = 0;
    endfunction

    function automatic void m_cpu_set(input logic [15:0] a, input logic [15:0] v);
        if (a == 16'd2) begin
            if (m_tx.size() < 8) m_tx.push_back(v);
            else m_tx_ovf = 1;
        end else if (a == 16'd3) begin
            m_tx_ovf = 0; m_rx_ovf = 0;
        end
    endfunction

    function automatic logic [15:0] m_cpu_get(input logic [15:0] a);
        if (a == 16'd2) begin
            if (m_rx.size() != 0) m_portout = m_rx.pop_front();
            else m_portout = 16'h0000;
        end else if (a == 16'd3) begin
            m_portout = {4'(m_rx.size()), 4'(m_tx.size()), 4'b0,
                         m_rx_ovf, m_tx_ovf, m_rx.size() != 0, m_tx.size() == 8};
        end
        return m_portout;
    endfunction

    function automatic logic [7:0] m_epp(input bit is_addr, input bit wr, input logic [7:0] din);
        logic [15:0] head;
        logic [7:0]  b;
        if (is_addr) begin
            if (wr) return m_addr;
            m_addr = din;
            return 8'h00;
        end
        if (wr) begin
            if (m_addr == 8'd0) begin
                if (m_tx.size() == 0) return 8'h00;
                head = m_tx[0];
                b = m_tx_tog ? head[15:8] : head[7:0];
                if (m_tx_tog) void'(m_tx.pop_front());
                m_tx_tog = !m_tx_tog;
                return b;
            end
            if (m_addr == 8'd2)
                return {4'b0, m_rx_ovf, m_tx_ovf, m_rx.size() == 8, m_tx.size() != 0};
            return 8'h00;
        end
        if (m_addr == 8'd1) begin
            if (!m_rx_tog) m_rx_low = din;
            else if (m_rx.size() < 8) m_rx.push_back({din, m_rx_low});
            else m_rx_ovf = 1;
            m_rx_tog = !m_rx_tog;
        end
        return 8'h00;
    endfunction

    // DUT-side bus tasks
    task automatic cpu_set(input logic [15:0] a, input logic [15:0] v);
        @(negedge mclk);
        portaddr = a; portval = v; portset = 1'b1;
        @(negedge mclk);
        portset = 1'b0;
    endtask

    task automatic cpu_get(input logic [15:0] a, output logic [15:0] r);
        @(negedge mclk);
        portaddr = a; portget = 1'b1;
        @(negedge mclk);
        portget = 1'b0;
        r = portout;
    endtask

    task automatic wait_for_wait(input logic lvl, input int budget, input string nm);
        int k;
        k = 0;
        while (usb_wait !== lvl && k < budget) begin
            @(negedge mclk);
            k++;
        end
        check(nm, usb_wait, lvl);
    endtask

    task automatic epp_xfer(input bit is_addr, input bit wr, input logic [7:0] din,
                            output logic [7:0] dout);
        @(negedge mclk);
        usb_write = wr; usb_db_in = din;
        if (is_addr) usb_astb = 1'b0; else usb_dstb = 1'b0;
        wait_for_wait(1'b1, 4, "wait_rise");
        @(negedge mclk);
        check("oe_hold", usb_db_oe, wr);
        dout = usb_db_out;
        usb_astb = 1'b1; usb_dstb = 1'b1;
        wait_for_wait(1'b0, 6, "wait_fall");
        check("oe_idle", usb_db_oe, 1'b0);
    endtask

    // Host data read whose ACT cycle coincides with a CPU push to PORT_DATA
    task automatic epp_read_with_push(input logic [15:0] v, output logic [7:0] dout);
        @(negedge mclk);
        usb_write = 1'b1; usb_dstb = 1'b0;
        wait_for_wait(1'b1, 4, "wait_rise_co");
        portaddr = 16'd2; portval = v; portset = 1'b1;
        @(negedge mclk);
        portset = 1'b0;
        dout = usb_db_out;
        usb_dstb = 1'b1;
        wait_for_wait(1'b0, 6, "wait_fall_co");
    endtask

    localparam int OP_SET = 0, OP_GET = 1, OP_AW = 2, OP_AR = 3, OP_DW = 4, OP_DR = 5;

    task automatic run_op(input int op, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] got, output logic [15:0] mexp);
        logic [7:0] b;
        got = '0; mexp = '0; b = '0;
        case (op)
            OP_SET: begin cpu_set(a, d); m_cpu_set(a, d); end
            OP_GET: begin cpu_get(a, got); mexp = m_cpu_get(a); end
            OP_AW:  begin epp_xfer(1, 0, d[7:0], b); void'(m_epp(1, 0, d[7:0])); end
            OP_AR:  begin epp_xfer(1, 1, 8'h00, b); got = {8'h00, b}; mexp = {8'h00, m_epp(1, 1, 8'h00)}; end
            OP_DW:  begin epp_xfer(0, 0, d[7:0], b); void'(m_epp(0, 0, d[7:0])); end
            OP_DR:  begin epp_xfer(0, 1, 8'h00, b); got = {8'h00, b}; mexp = {8'h00, m_epp(0, 1, 8'h00)}; end
            default: ;
        endcase
    endtask

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        bit          chk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int op, input logic [15:0] a, input logic [15:0] d,
                                input logic [15:0] e, input bit c);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e; v.chk = c;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got, mexp;
        logic [7:0]  b;
        int          op;

        rst_n = 1'b0; portaddr = '0; portval = '0; portget = 1'b0; portset = 1'b0;
        usb_write = 1'b0; usb_astb = 1'b1; usb_dstb = 1'b1; usb_db_in = '0;
        m_reset();
        repeat (3) @(negedge mclk);
        check("rst_portout", portout, 16'h0000);
        check("rst_wait", usb_wait, 1'b0);
        check("rst_oe", usb_db_oe, 1'b0);
        check("rst_dbout", usb_db_out, 8'h00);
        rst_n = 1'b1;

        add(OP_GET, 3, 0, 16'h0000, 1);
        add(OP_SET, 2, 16'hBEEF, 0, 0);
        add(OP_AW, 0, 16'h0000, 0, 0);
        add(OP_AR, 0, 0, 16'h0000, 1);
        add(OP_DR, 0, 0, 16'h00EF, 1);
        add(OP_DR, 0, 0, 16'h00BE, 1);
        add(OP_GET, 3, 0, 16'h0000, 1);
        add(OP_AW, 0, 16'h0001, 0, 0);
        add(OP_AR, 0, 0, 16'h0001, 1);
        add(OP_DW, 0, 16'h0034, 0, 0);
        add(OP_DW, 0, 16'h0012, 0, 0);
        add(OP_GET, 3, 0, 16'h1002, 1);
        add(OP_GET, 7, 0, 16'h1002, 1);
        add(OP_GET, 2, 0, 16'h1234, 1);
        add(OP_GET, 2, 0, 16'h0000, 1);
        add(OP_AW, 0, 16'h0000, 0, 0);
        add(OP_DR, 0, 0, 16'h0000, 1);
        add(OP_AW, 0, 16'h0002, 0, 0);
        add(OP_DR, 0, 0, 16'h0000, 1);
        add(OP_AW, 0, 16'h0005, 0, 0);
        add(OP_DW, 0, 16'h0099, 0, 0);
        add(OP_DR, 0, 0, 16'h0000, 1);
        add(OP_GET, 3, 0, 16'h0000, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].data, got, mexp);
            if (vecs[i].chk) check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // TX overflow: ninth word dropped, then drain in byte order
        for (int i = 1; i <= 9; i++) run_op(OP_SET, 2, 16'(i), got, mexp);
        run_op(OP_GET, 3, 0, got, mexp);
        check("ovf_status", got, 16'h0805);
        run_op(OP_AW, 0, 16'h0002, got, mexp);
        run_op(OP_DR, 0, 0, got, mexp);
        check("ovf_epp_status", got, 16'h0005);
        run_op(OP_AW, 0, 16'h0000, got, mexp);
        for (int j = 0; j < 16; j++) begin
            run_op(OP_DR, 0, 0, got, mexp);
            check($sformatf("drain%0d", j), got, (j % 2 == 0) ? 16'(j / 2 + 1) : 16'h0000);
        end
        run_op(OP_GET, 3, 0, got, mexp);
        check("ovf_sticky", got, 16'h0004);
        run_op(OP_SET, 3, 0, got, mexp);
        run_op(OP_GET, 3, 0, got, mexp);
        check("ovf_cleared", got, 16'h0000);

        // Host pop of a high byte coinciding with a CPU push: 7 words, then full
        for (int i = 1; i <= 7; i++) run_op(OP_SET, 2, 16'h0A00 + 16'(i), got, mexp);
        run_op(OP_DR, 0, 0, got, mexp);
        check("co7_low", got, 16'h0001);
        epp_read_with_push(16'h0B00, b);
        void'(m_epp(0, 1, 8'h00)); m_cpu_set(2, 16'h0B00);
        check("co7_high", b, 8'h0A);
        run_op(OP_GET, 3, 0, got, mexp);
        check("co7_status", got, 16'h0700);
        run_op(OP_SET, 2, 16'h0B01, got, mexp);
        run_op(OP_DR, 0, 0, got, mexp);
        check("co8_low", got, 16'h0002);
        epp_read_with_push(16'h0B02, b);
        void'(m_epp(0, 1, 8'h00)); m_cpu_set(2, 16'h0B02);
        check("co8_high", b, 8'h0A);
        run_op(OP_GET, 3, 0, got, mexp);
        check("co8_status", got, 16'h0801);

        // Reset during HOLD with pending TX data and a half-assembled RX word
        run_op(OP_AW, 0, 16'h0001, got, mexp);
        run_op(OP_DW, 0, 16'h0077, got, mexp);
        @(negedge mclk);
        usb_write = 1'b1; usb_dstb = 1'b0;
        wait_for_wait(1'b1, 4, "wait_rise_rst");
        @(negedge mclk);
        check("hold_wait", usb_wait, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_wait", usb_wait, 1'b0);
        check("midrst_oe", usb_db_oe, 1'b0);
        check("midrst_dbout", usb_db_out, 8'h00);
        check("midrst_portout", portout, 16'h0000);
        usb_dstb = 1'b1;
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        m_reset();
        run_op(OP_GET, 3, 0, got, mexp);
        check("postrst_status", got, 16'h0000);
        run_op(OP_AW, 0, 16'h0001, got, mexp);
        run_op(OP_DW, 0, 16'h00AA, got, mexp);
        run_op(OP_DW, 0, 16'h0055, got, mexp);
        run_op(OP_GET, 2, 0, got, mexp);
        check("postrst_rx", got, 16'h55AA);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a, d;
            int r;
            r = $urandom_range(0, 9);
            a = '0; d = 16'($urandom);
            case (r)
                0, 1, 2: begin op = OP_SET; a = ($urandom_range(0, 5) == 0) ? 16'd3 : 16'd2; end
                3:       begin op = OP_GET; a = 16'd2; end
                4:       begin op = OP_GET; a = 16'd3; end
                5:       begin op = OP_GET; a = 16'($urandom_range(0, 7)); end
                6:       begin op = OP_AW;  d = ($urandom_range(0, 7) == 0) ? d : 16'($urandom_range(0, 3)); end
                7:       op = OP_AR;
                8:       op = OP_DR;
                default: op = OP_DW;
            endcase
            run_op(op, a, d, got, mexp);
            if (op == OP_GET || op == OP_AR || op == OP_DR)
                check($sformatf("rand%0d_op%0d", n, op), got, mexp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
